// File: rtl/pcs_pkg.sv
// Shared PCS definitions for the GMII transmit scheduler: FSM state encoding,
// preamble/SFD constants and a saturating counter helper.
package pcs_pkg;

  typedef enum logic [2:0] {
    LINK_DOWN = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    DATA      = 3'd3,
    IPG       = 3'd4,
    DRAIN     = 3'd5
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_tx_sched_link_qualifier.sv
// Link qualifier: link_up is asserted once code_sync_status has been high for
// SYNC_HOLD consecutive cycles; a single low cycle restarts the count.
module link_qualifier #(
  parameter int SYNC_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic code_sync_status,
  output logic link_up
);

  localparam logic [7:0] HOLD = 8'(SYNC_HOLD);

  logic [7:0] sync_cnt;

  // Consecutive-sync counter, saturating at SYNC_HOLD, cleared by any loss of sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_cnt <= '0;
    end else if (!code_sync_status) begin
      sync_cnt <= '0;
    end else if (sync_cnt != HOLD) begin
      sync_cnt <= sync_cnt + 8'd1;
    end
  end

  assign link_up = (sync_cnt == HOLD);

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII transmit scheduler: qualifies the link, round-robins two byte-stream
// requesters onto TXD/TX_EN/TX_ER, prepends preamble+SFD, enforces the IPG and
// aborts/drains frames on link loss.
// Optional frame statistics outputs are enabled by defining GMII_TX_SCHED_STATS_EN.
//
// Requester handshake: a byte moves when REQn_valid & REQn_ready are both high
// on a rising edge of GTX_CLK; ready depends only on state and grant, never on
// valid, and is only high for the granted requester in DATA or DRAIN.
module gmii_tx_sched
  import pcs_pkg::*;
#(
  parameter int IPG_CYCLES = 12,
  parameter int SYNC_HOLD  = 16
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       code_sync_status,
  input  logic       transmitting,
  input  logic       REQ0_valid,
  input  logic [7:0] REQ0_data,
  input  logic       REQ0_last,
  output logic       REQ0_ready,
  input  logic       REQ1_valid,
  input  logic [7:0] REQ1_data,
  input  logic       REQ1_last,
  output logic       REQ1_ready,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       link_up,
  output logic       grant,
  output tx_state_t  state
`ifdef GMII_TX_SCHED_STATS_EN
  ,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_errored
`endif
);

  localparam logic [7:0] IPG_LAST = 8'(IPG_CYCLES - 1);
  localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_LEN);

  logic [2:0] pre_cnt;
  logic [7:0] ipg_cnt;
  logic       cur_valid;
  logic       cur_last;
  logic [7:0] cur_data;
  logic       xfer_state;
  logic       grant_fire;
  logic       next_grant;

  link_qualifier #(.SYNC_HOLD(SYNC_HOLD)) u_link_qualifier (
    .clk              (GTX_CLK),
    .rst_n            (mr_main_reset),
    .code_sync_status (code_sync_status),
    .link_up          (link_up)
  );

  // Mux of the currently granted requester.
  assign cur_valid  = grant ? REQ1_valid : REQ0_valid;
  assign cur_last   = grant ? REQ1_last  : REQ0_last;
  assign cur_data   = grant ? REQ1_data  : REQ0_data;

  assign xfer_state = (state == DATA) || (state == DRAIN);
  assign REQ0_ready = xfer_state && !grant;
  assign REQ1_ready = xfer_state && grant;

  // A new frame starts from IDLE only on a healthy, quiet link.
  assign grant_fire = link_up && !transmitting && (REQ0_valid || REQ1_valid);
  // Contention flips the grant; a lone requester simply takes it.
  assign next_grant = (REQ0_valid && REQ1_valid) ? ~grant : REQ1_valid;

  // Main sequencer with registered GMII outputs.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state   <= LINK_DOWN;
      grant   <= 1'b1;
      TXD     <= 8'h00;
      TX_EN   <= 1'b0;
      TX_ER   <= 1'b0;
      pre_cnt <= '0;
      ipg_cnt <= '0;
    end else begin
      TXD   <= 8'h00;
      TX_EN <= 1'b0;
      TX_ER <= 1'b0;
      case (state)
        LINK_DOWN: begin
          if (link_up) state <= IDLE;
        end
        IDLE: begin
          if (!link_up) begin
            state <= LINK_DOWN;
          end else if (grant_fire) begin
            grant   <= next_grant;
            state   <= PREAMBLE;
            TXD     <= PREAMBLE_BYTE;
            TX_EN   <= 1'b1;
            pre_cnt <= 3'd1;
          end
        end
        PREAMBLE: begin
          TX_EN <= 1'b1;
          if (!link_up) begin
            TX_ER <= 1'b1;
            state <= DRAIN;
          end else if (pre_cnt == PRE_LAST) begin
            TXD   <= SFD_BYTE;
            state <= DATA;
          end else begin
            TXD     <= PREAMBLE_BYTE;
            pre_cnt <= pre_cnt + 3'd1;
          end
        end
        DATA: begin
          TX_EN <= 1'b1;
          if (!link_up) begin
            // Abort symbol; a last taken in this same cycle means nothing is left to drain.
            TX_ER <= 1'b1;
            state <= (cur_valid && cur_last) ? LINK_DOWN : DRAIN;
          end else if (cur_valid) begin
            TXD <= cur_data;
            if (cur_last) begin
              state   <= IPG;
              ipg_cnt <= '0;
            end
          end else begin
            // Underrun: flag the gap as an error symbol and keep the frame going.
            TX_ER <= 1'b1;
          end
        end
        IPG: begin
          // The first IPG cycle still shows the final byte, so IPG_CYCLES idle
          // symbols have gone out once the count reaches IPG_CYCLES-1.
          if (!link_up) begin
            state <= LINK_DOWN;
          end else if (ipg_cnt >= IPG_LAST) begin
            if (!transmitting) state <= IDLE;
          end else begin
            ipg_cnt <= ipg_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (cur_valid && cur_last) begin
            if (link_up) begin
              state   <= IPG;
              ipg_cnt <= '0;
            end else begin
              state <= LINK_DOWN;
            end
          end
        end
        default: state <= LINK_DOWN;
      endcase
    end
  end

`ifdef GMII_TX_SCHED_STATS_EN
  logic frame_err;
  logic err_event;

  assign err_event = ((state == PREAMBLE) && !link_up) ||
                     ((state == DATA) && (!link_up || !cur_valid));

  // Frame statistics: good completions and frames hit by underrun or abort (once each).
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      frames_sent    <= '0;
      frames_errored <= '0;
      frame_err      <= 1'b0;
    end else begin
      if ((state == IDLE) && grant_fire) frame_err <= 1'b0;
      if ((state == DATA) && link_up && cur_valid && cur_last)
        frames_sent <= sat_inc16(frames_sent);
      if (err_event && !frame_err) begin
        frames_errored <= sat_inc16(frames_errored);
        frame_err      <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Self-checking bench for gmii_tx_sched: directed link/frame/abort/reset steps
// followed by randomized multi-frame rounds checked against a frame-level model.
module tb_gmii_tx_sched;
  import pcs_pkg::*;

  localparam int IPG = 12;
  localparam int SH  = 16;

  // Clock and reset.
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       code_sync_status = 1'b0;
  logic       transmitting     = 1'b0;
  logic       r0_valid = 1'b0, r0_last = 1'b0, r0_ready;
  logic [7:0] r0_data  = 8'h00;
  logic       r1_valid = 1'b0, r1_last = 1'b0, r1_ready;
  logic [7:0] r1_data  = 8'h00;
  logic [7:0] txd;
  logic       tx_en, tx_er, link_up, grant;
  tx_state_t  dbg_state;
`ifdef GMII_TX_SCHED_STATS_EN
  logic [15:0] frames_sent, frames_errored;
`endif

  gmii_tx_sched #(.IPG_CYCLES(IPG), .SYNC_HOLD(SH)) dut (
    .GTX_CLK          (clk),
    .mr_main_reset    (rst_n),
    .code_sync_status (code_sync_status),
    .transmitting     (transmitting),
    .REQ0_valid       (r0_valid),
    .REQ0_data        (r0_data),
    .REQ0_last        (r0_last),
    .REQ0_ready       (r0_ready),
    .REQ1_valid       (r1_valid),
    .REQ1_data        (r1_data),
    .REQ1_last        (r1_last),
    .REQ1_ready       (r1_ready),
    .TXD              (txd),
    .TX_EN            (tx_en),
    .TX_ER            (tx_er),
    .link_up          (link_up),
    .grant            (grant),
    .state            (dbg_state)
`ifdef GMII_TX_SCHED_STATS_EN
    ,
    .frames_sent      (frames_sent),
    .frames_errored   (frames_errored)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Source queues: {valid, last, data}; a valid=0 entry is an underrun slot.
  logic [9:0] src0_q[$], src1_q[$];
  // Model: expected output symbols {tx_en, tx_er, txd} per requester.
  logic [9:0] mdl0_q[$], mdl1_q[$];
  int         flen0_q[$], flen1_q[$];
  logic [9:0] exp_sym_q[$];
  int         exp_len_q[$];
  logic       exp_req_q[$];
  logic       model_last = 1'b1;
  int         exp_sent = 0, exp_err = 0;
  // Captured DUT output per cycle.
  logic [9:0] cap_q[$];
  logic       cap_grant[$];
  bit         rand_trans = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present the head of each source queue.
  task automatic drive_inputs();
    r0_valid = (src0_q.size() > 0) && src0_q[0][9];
    r0_last  = (src0_q.size() > 0) && src0_q[0][8];
    r0_data  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
    r1_valid = (src1_q.size() > 0) && src1_q[0][9];
    r1_last  = (src1_q.size() > 0) && src1_q[0][8];
    r1_data  = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
  endtask

  // One clock: consume entries the DUT was ready for, then sample outputs at +1.
  task automatic cycle();
    logic take0, take1;
    take0 = r0_ready && (src0_q.size() > 0);
    take1 = r1_ready && (src1_q.size() > 0);
    @(posedge clk);
    #1;
    if (take0) void'(src0_q.pop_front());
    if (take1) void'(src1_q.pop_front());
    cap_q.push_back({tx_en, tx_er, txd});
    cap_grant.push_back(grant);
    if (rand_trans) transmitting = ($urandom_range(0, 7) == 0);
    drive_inputs();
  endtask

  // Queue a frame on a requester and its expected symbol stream in the model.
  task automatic add_frame(input bit req, input int n, input int gap_pos, input int gap_len,
                           input logic [7:0] base, input bit rnd);
    logic [7:0] d;
    logic [9:0] e;
    int syms;
    syms = 8;
    for (int i = 0; i < 7; i++) begin
      if (req) mdl1_q.push_back({2'b10, 8'h55}); else mdl0_q.push_back({2'b10, 8'h55});
    end
    if (req) mdl1_q.push_back({2'b10, 8'hD5}); else mdl0_q.push_back({2'b10, 8'hD5});
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      e = {1'b1, (i == n - 1), d};
      if (req) begin src1_q.push_back(e); mdl1_q.push_back({2'b10, d}); end
      else     begin src0_q.push_back(e); mdl0_q.push_back({2'b10, d}); end
      syms++;
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          if (req) begin src1_q.push_back(10'h000); mdl1_q.push_back({2'b11, 8'h00}); end
          else     begin src0_q.push_back(10'h000); mdl0_q.push_back({2'b11, 8'h00}); end
          syms++;
        end
      end
    end
    if (req) flen1_q.push_back(syms); else flen0_q.push_back(syms);
    exp_sent++;
    if (gap_pos >= 0 && gap_len > 0) exp_err++;
  endtask

  // Round-robin order at frame level: alternate while both have frames pending.
  task automatic build_expected();
    int n;
    logic pick;
    while (flen0_q.size() > 0 || flen1_q.size() > 0) begin
      if (flen0_q.size() > 0 && flen1_q.size() > 0) pick = ~model_last;
      else pick = (flen1_q.size() > 0);
      model_last = pick;
      if (pick) begin
        n = flen1_q.pop_front();
        for (int i = 0; i < n; i++) exp_sym_q.push_back(mdl1_q.pop_front());
      end else begin
        n = flen0_q.pop_front();
        for (int i = 0; i < n; i++) exp_sym_q.push_back(mdl0_q.pop_front());
      end
      exp_len_q.push_back(n);
      exp_req_q.push_back(pick);
    end
  endtask

  // Scoreboard: split the captured stream into TX_EN runs and match them.
  task automatic compare_runs(input string tag, input bit exact_gap);
    int idx, gap, n;
    bit first, trunc;
    logic r;
    logic [9:0] s;
    idx = 0; gap = 0; first = 1'b1; trunc = 1'b0;
    while (idx < cap_q.size() && !trunc) begin
      if (!cap_q[idx][9]) begin
        gap++;
        idx++;
      end else begin
        if (exp_len_q.size() == 0) begin
          chk({tag, "_extra_frame"}, 32'(cap_q.size() - idx), 0);
          break;
        end
        n = exp_len_q.pop_front();
        r = exp_req_q.pop_front();
        chk({tag, "_grant"}, cap_grant[idx], r);
        if (!first) begin
          if (exact_gap) chk({tag, "_ipg_exact"}, gap, IPG);
          else chk({tag, "_ipg_min"}, (gap >= IPG), 1);
        end
        for (int j = 0; j < n; j++) begin
          s = exp_sym_q.pop_front();
          if (idx < cap_q.size()) begin
            chk({tag, "_sym"}, cap_q[idx], s);
            idx++;
          end else begin
            chk({tag, "_truncated"}, idx, 32'(cap_q.size() + n));
            trunc = 1'b1;
            break;
          end
        end
        if (idx < cap_q.size()) chk({tag, "_run_end"}, cap_q[idx][9], 0);
        first = 1'b0;
        gap = 0;
      end
    end
    chk({tag, "_frames_missing"}, exp_len_q.size(), 0);
    exp_sym_q.delete();
    exp_len_q.delete();
    exp_req_q.delete();
  endtask

  // Run queued frames to completion (bounded) and score them.
  task automatic run_frames(input string tag, input bit exact_gap, input int budget);
    int cyc;
    cap_q.delete();
    cap_grant.delete();
    drive_inputs();
    cyc = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0) && cyc < budget) begin
      cycle();
      cyc++;
    end
    chk({tag, "_timeout"}, (cyc < budget), 1);
    transmitting = 1'b0;
    repeat (IPG + 4) cycle();
    build_expected();
    compare_runs(tag, exact_gap);
`ifdef GMII_TX_SCHED_STATS_EN
    chk({tag, "_frames_sent"}, frames_sent, exp_sent);
    chk({tag, "_frames_errored"}, frames_errored, exp_err);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_txd"}, txd, 8'h00);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_tx_er"}, tx_er, 0);
    chk({tag, "_link_up"}, link_up, 0);
    chk({tag, "_grant"}, grant, 1);
    chk({tag, "_ready0"}, r0_ready, 0);
    chk({tag, "_ready1"}, r1_ready, 0);
    chk({tag, "_state"}, dbg_state, LINK_DOWN);
`ifdef GMII_TX_SCHED_STATS_EN
    chk({tag, "_stat_sent"}, frames_sent, 0);
    chk({tag, "_stat_err"}, frames_errored, 0);
`endif
  endtask

  task automatic relink(input string tag);
    code_sync_status = 1'b1;
    repeat (SH + 1) cycle();
    chk({tag, "_idle"}, dbg_state, IDLE);
  endtask

  initial begin
    logic [7:0] exp_b;
    int guard;
    int n0, n1, len, gpos;

    // Reset state.
    repeat (3) cycle();
    check_reset_values("reset");
    rst_n = 1'b1;

    // Link-up debounce: 15 high, 1 low, then 16 high.
    code_sync_status = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("debounce_first_run", link_up, 0);
    end
    code_sync_status = 1'b0;
    cycle();
    chk("debounce_drop", link_up, 0);
    code_sync_status = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("debounce_second_run", link_up, (i == 15));
    end
    cycle();
    chk("link_to_idle", dbg_state, IDLE);

    // Single frame from REQ0: A1 A2 A3.
    src0_q.push_back({2'b10, 8'hA1});
    src0_q.push_back({2'b10, 8'hA2});
    src0_q.push_back({2'b11, 8'hA3});
    drive_inputs();
    for (int i = 1; i <= 11; i++) begin
      cycle();
      exp_b = (i <= 7) ? 8'h55 : (i == 8) ? 8'hD5 : 8'hA1 + 8'(i - 9);
      chk("single_sym", {tx_en, tx_er, txd}, {2'b10, exp_b});
      chk("single_ready0", r0_ready, (i >= 8 && i <= 10));
      chk("single_ready1", r1_ready, 0);
      chk("single_grant", grant, 0);
    end
    for (int i = 0; i < IPG; i++) begin
      cycle();
      chk("single_ipg", tx_en, 0);
    end
    model_last = 1'b0;
    exp_sent++;

    // Round-robin, both requesters continuously valid with 2-byte frames.
    add_frame(1'b0, 2, -1, 0, 8'h10, 1'b0);
    add_frame(1'b0, 2, -1, 0, 8'h12, 1'b0);
    add_frame(1'b1, 2, -1, 0, 8'h20, 1'b0);
    add_frame(1'b1, 2, -1, 0, 8'h22, 1'b0);
    run_frames("rr", 1'b1, 400);

    // Underrun: REQ1 drops valid for 2 cycles mid-frame.
    add_frame(1'b1, 4, 1, 2, 8'hC1, 1'b0);
    run_frames("underrun", 1'b1, 200);

    // Link loss in DATA.
    for (int i = 0; i < 12; i++) src0_q.push_back({1'b1, (i == 11), 8'h30 + 8'(i)});
    drive_inputs();
    guard = 0;
    while (!(tx_en && txd == 8'hD5) && guard < 40) begin
      cycle();
      guard++;
    end
    chk("linkloss_sfd_seen", (guard < 40), 1);
    repeat (2) cycle();
    code_sync_status = 1'b0;
    cycle();
    chk("linkloss_link_down", link_up, 0);
    chk("linkloss_last_byte", {tx_en, tx_er}, 2'b10);
    cycle();
    chk("linkloss_abort", {tx_en, tx_er, txd}, {2'b11, 8'h00});
    chk("linkloss_drain_state", dbg_state, DRAIN);
    guard = 0;
    while (src0_q.size() > 0 && guard < 40) begin
      cycle();
      chk("linkloss_drain_quiet", tx_en, 0);
      guard++;
    end
    chk("linkloss_drained", src0_q.size(), 0);
    chk("linkloss_state", dbg_state, LINK_DOWN);
    chk("linkloss_ready", r0_ready, 0);
    exp_err++;
`ifdef GMII_TX_SCHED_STATS_EN
    chk("linkloss_frames_sent", frames_sent, exp_sent);
    chk("linkloss_frames_errored", frames_errored, exp_err);
`endif
    relink("relink1");

    // Asynchronous reset in the middle of a REQ0 preamble.
    for (int i = 0; i < 4; i++) src0_q.push_back({1'b1, (i == 3), 8'h40 + 8'(i)});
    drive_inputs();
    guard = 0;
    while (!tx_en && guard < 20) begin
      cycle();
      guard++;
    end
    chk("areset_preamble_seen", {tx_en, txd}, {1'b1, 8'h55});
    repeat (2) cycle();
    chk("areset_grant_before", grant, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("areset");
    src0_q.delete();
    src1_q.delete();
    drive_inputs();
    repeat (2) cycle();
    rst_n = 1'b1;
    exp_sent = 0;
    exp_err = 0;
    model_last = 1'b1;
    relink("relink2");

    // Randomized rounds against the frame-level model.
    rand_trans = 1'b1;
    for (int r = 0; r < 6; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int f = 0; f < n0 + n1; f++) begin
        len = $urandom_range(1, 8);
        gpos = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 2) : -1;
        add_frame((f >= n0), len, gpos, $urandom_range(1, 3), 8'h00, 1'b1);
      end
      run_frames("random", 1'b0, 3000);
    end
    rand_trans = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
